acs_array_norm: RTL
===================

# acs_array_norm

Parametrised add-compare-select array for the phy_wifi Viterbi decoder, successor to the fixed 4-butterfly ACS unit. Processes one trellis segment per accepted beat and keeps both path-metric banks internally as ping-pong registers, so no external metric memory is needed. Adds saturating arithmetic, automatic metric renormalisation, per-symbol best-state reporting, a valid/ready input handshake and synchronous re-initialisation. Survivor bits go to the survivor memory; BestState feeds traceback.

## Interface
Parameters:
- STATES, 64: trellis states, 2^(K-1); power of 2, ≥4.
- ACS_PER_CYCLE, 4: butterflies per beat (P); power of 2, divides STATES/2.
- METRIC_W, 8: path-metric width.
- DIST_W, 2: branch-distance width.
- INIT_PENALTY, 32: initial metric of states 1..STATES-1; must be < 2^(METRIC_W-1).
- Derived: SEGMENTS = STATES/(2P); SEG_W = max(1, log2 SEGMENTS); ST_W = log2 STATES.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Init  in  1  synchronous re-initialisation; priority over all other inputs.
- Hold  in  1  stall; no beat accepted.
- DistValid  in  1  Distance valid.
- DistReady  out  1  = !Hold && !Init (combinational).
- Distance  in  2·P·DIST_W  butterfly j: dA_j = Distance[2j·DIST_W +: DIST_W], dB_j = Distance[(2j+1)·DIST_W +: DIST_W].
- SurvValid  out  1  Survivors valid.
- SurvSegment  out  SEG_W  segment index of Survivors.
- Survivors  out  2P  bit 2j: decision for state 2b; bit 2j+1: decision for state 2b+1.
- SymbolDone  out  1  one-cycle pulse, symbol complete.
- BestState  out  ST_W  lowest-metric state of completed symbol.
- BestMetric  out  METRIC_W  its metric, pre-normalisation.
- NormEvent  out  1  pulse with SymbolDone when renormalisation is scheduled.

## Operation
- Accept when DistValid && DistReady. The segment counter seg (0..SEGMENTS-1) advances per accept and wraps to 0 after SEGMENTS-1. Wrap swaps the read and write banks.
- Butterfly j of segment seg: b = seg·P + j.
  - Predecessors: lo = old[b], hi = old[b+STATES/2].
  - new[2b] = min(lo+dA, hi+dB); new[2b+1] = min(lo+dB, hi+dA).
  - Decision bit = 1 iff the hi candidate is strictly smaller. Ties select lo (bit 0).
- Sums are computed at METRIC_W+1 bits and saturate to 2^METRIC_W-1.
- Renormalisation:
  - A running min and its index are tracked over all new metrics of the symbol. On a tie, the lower index wins.
  - If the symbol min is ≥ 2^(METRIC_W-1), norm_pending is set at wrap.
  - While norm_pending is set, every old metric read in the next symbol has 2^(METRIC_W-1) subtracted before the add. The flag clears at that symbol's wrap unless it is set again.
- Reset or Init:
  - Read bank: state 0 = 0, all other states = INIT_PENALTY.
  - seg = 0; norm_pending, running min and all outputs cleared.
  - A partial symbol is discarded with no SymbolDone.
- Hold: state frozen; outputs deassert valids next cycle.

## Timing
- Latency 1: survivors for a beat accepted at edge n are registered at edge n and visible in cycle n+1 with SurvValid=1. SurvValid=0 in any cycle following a non-accept.
- On the last-segment accept, SymbolDone, BestState, BestMetric and NormEvent update in the same cycle as the final SurvValid. BestState and BestMetric hold until the next SymbolDone.
- No bubble between symbols: back-to-back accepts sustain one segment per cycle indefinitely.
- Simultaneous events:
  - Init with DistValid: no accept.
  - Init with Hold: Init wins.
  - Init in the wrap cycle: no SymbolDone.
- Reset values: SurvValid 0, SurvSegment 0, Survivors 0, SymbolDone 0, BestState 0, BestMetric 0, NormEvent 0. DistReady follows Hold/Init.
- Reset asserted mid-symbol clears all state asynchronously; the first accept after release is segment 0.

## Test plan
- Reset, 8 back-to-back beats of all-zero Distance: SurvSegment 0..7 on consecutive cycles, Survivors = 0 each beat, SymbolDone on the 8th, BestState 0, BestMetric 0, NormEvent 0.
- INIT_PENALTY=0 build, segment 0 with butterfly 0 dA=3, dB=0, others 0: Survivors[1:0] = 2'b01 (state 0 from hi, state 1 from lo), all other bits 0.
- All distances 3, continuous: BestMetric = 3n after symbol n. Symbol 43 reports 129 with NormEvent=1. Symbol 44 reports 4, NormEvent 0. No metric saturates.
- DistValid held high, Hold=1 for 3 cycles during segment 3: DistReady 0, SurvValid 0 for those cycles; next accepts resume at segment 3 with no skipped or duplicate SurvSegment.
- Init pulsed after 5 accepted segments: no SymbolDone; next accepted beat reports SurvSegment 0. A following zero-distance symbol reproduces scenario 1 exactly.
- STATES=16, P=2 build (SEGMENTS=4), zero distances: SymbolDone every 4 accepts, BestState 0; Reset asserted mid-symbol forces all outputs to 0 immediately.

Source files
------------

// File: rtl/acs_array_norm.sv
// Add-compare-select array with internal ping-pong path-metric banks,
// saturating adds, automatic renormalisation and per-symbol best-state report.

// One radix-2 butterfly: two predecessors, two successors, two decisions.
module acs_bfly #(
  parameter int METRIC_W = 8,
  parameter int DIST_W   = 2
) (
  input  logic [METRIC_W-1:0] lo,
  input  logic [METRIC_W-1:0] hi,
  input  logic [DIST_W-1:0]   da,
  input  logic [DIST_W-1:0]   db,
  input  logic                norm,
  output logic [METRIC_W-1:0] m_even,
  output logic [METRIC_W-1:0] m_odd,
  output logic                dec_even,
  output logic                dec_odd
);
  localparam logic [METRIC_W-1:0] HALF = {1'b1, {(METRIC_W-1){1'b0}}};

  logic [METRIC_W-1:0] lo_n, hi_n, c_lo_a, c_lo_b, c_hi_a, c_hi_b;

  // Add at METRIC_W+1 bits, clamp to all-ones on carry out.
  function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] m,
                                                  input logic [DIST_W-1:0] d);
    logic [METRIC_W:0] s;
    s = {1'b0, m} + {{(METRIC_W+1-DIST_W){1'b0}}, d};
    return s[METRIC_W] ? {METRIC_W{1'b1}} : s[METRIC_W-1:0];
  endfunction

  // Renormalised predecessors never underflow: the previous symbol min was >= HALF.
  assign lo_n   = norm ? lo - HALF : lo;
  assign hi_n   = norm ? hi - HALF : hi;
  assign c_lo_a = sat_add(lo_n, da);
  assign c_lo_b = sat_add(lo_n, db);
  assign c_hi_a = sat_add(hi_n, da);
  assign c_hi_b = sat_add(hi_n, db);

  // Strict compare so ties resolve to the lo predecessor.
  assign dec_even = c_hi_b < c_lo_a;
  assign m_even   = dec_even ? c_hi_b : c_lo_a;
  assign dec_odd  = c_hi_a < c_lo_b;
  assign m_odd    = dec_odd ? c_hi_a : c_lo_b;
endmodule

module acs_array_norm #(
  parameter int STATES        = 64,
  parameter int ACS_PER_CYCLE = 4,
  parameter int METRIC_W      = 8,
  parameter int DIST_W        = 2,
  parameter int INIT_PENALTY  = 32,
  localparam int P        = ACS_PER_CYCLE,
  localparam int SEGMENTS = STATES / (2 * ACS_PER_CYCLE),
  localparam int SEG_W    = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1,
  localparam int ST_W     = $clog2(STATES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init,
  input  logic                     hold,
  input  logic                     dist_valid,
  output logic                     dist_ready,
  input  logic [2*P*DIST_W-1:0]    distance,
  output logic                     surv_valid,
  output logic [SEG_W-1:0]         surv_segment,
  output logic [2*P-1:0]           survivors,
  output logic                     symbol_done,
  output logic [ST_W-1:0]          best_state,
  output logic [METRIC_W-1:0]      best_metric,
  output logic                     norm_event
);
  localparam logic [METRIC_W-1:0] HALF     = {1'b1, {(METRIC_W-1){1'b0}}};
  localparam logic [METRIC_W-1:0] INIT_M   = METRIC_W'(INIT_PENALTY);
  localparam logic [SEG_W-1:0]    SEG_LAST = SEG_W'(SEGMENTS - 1);

  // bank[sel] holds the previous symbol's metrics, bank[~sel] collects the new ones
  logic [METRIC_W-1:0]             bank [2][STATES];
  logic                            sel;
  logic [SEG_W-1:0]                seg;
  logic                            norm_pending;
  logic [METRIC_W-1:0]             run_min, beat_min, sym_min;
  logic [ST_W-1:0]                 run_idx, beat_idx, sym_idx;
  logic [P-1:0][METRIC_W-1:0]      lo, hi, m_even, m_odd;
  logic [P-1:0]                    dec_even, dec_odd;
  logic [2*P-1:0][METRIC_W-1:0]    new_m;
  logic [2*P-1:0]                  dec;
  logic                            accept, last, wrap;

  assign dist_ready = !hold && !init;
  assign accept     = dist_valid && dist_ready;
  assign last       = (seg == SEG_LAST);
  assign wrap       = accept && last;

  // Fetch butterfly predecessors b and b+STATES/2 from the read bank.
  always_comb begin
    for (int j = 0; j < P; j++) begin
      lo[j] = bank[sel][ST_W'(int'(seg) * P + j)];
      hi[j] = bank[sel][ST_W'(int'(seg) * P + j + STATES / 2)];
    end
  end

  for (genvar j = 0; j < P; j++) begin : g_bfly
    acs_bfly #(.METRIC_W(METRIC_W), .DIST_W(DIST_W)) u_bfly (
      .lo       (lo[j]),
      .hi       (hi[j]),
      .da       (distance[2*j*DIST_W +: DIST_W]),
      .db       (distance[(2*j+1)*DIST_W +: DIST_W]),
      .norm     (norm_pending),
      .m_even   (m_even[j]),
      .m_odd    (m_odd[j]),
      .dec_even (dec_even[j]),
      .dec_odd  (dec_odd[j])
    );
    assign new_m[2*j]   = m_even[j];
    assign new_m[2*j+1] = m_odd[j];
    assign dec[2*j]     = dec_even[j];
    assign dec[2*j+1]   = dec_odd[j];
  end

  // Minimum of this beat's 2P new metrics; ascending scan keeps the lowest index on ties.
  always_comb begin
    beat_min = new_m[0];
    beat_idx = ST_W'(int'(seg) * 2 * P);
    for (int k = 1; k < 2 * P; k++) begin
      if (new_m[k] < beat_min) begin
        beat_min = new_m[k];
        beat_idx = ST_W'(int'(seg) * 2 * P + k);
      end
    end
  end

  // Fold beat minimum into the running symbol minimum; earlier segments win ties.
  always_comb begin
    sym_min = beat_min;
    sym_idx = beat_idx;
    if (seg != '0 && !(beat_min < run_min)) begin
      sym_min = run_min;
      sym_idx = run_idx;
    end
  end

  // Metric banks, segment sequencing and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STATES; s++) begin
        bank[0][s] <= (s == 0) ? '0 : INIT_M;
        bank[1][s] <= (s == 0) ? '0 : INIT_M;
      end
      sel          <= 1'b0;
      seg          <= '0;
      norm_pending <= 1'b0;
      run_min      <= '0;
      run_idx      <= '0;
      surv_valid   <= 1'b0;
      surv_segment <= '0;
      survivors    <= '0;
      symbol_done  <= 1'b0;
      best_state   <= '0;
      best_metric  <= '0;
      norm_event   <= 1'b0;
    end else if (init) begin
      for (int s = 0; s < STATES; s++) begin
        bank[0][s] <= (s == 0) ? '0 : INIT_M;
        bank[1][s] <= (s == 0) ? '0 : INIT_M;
      end
      sel          <= 1'b0;
      seg          <= '0;
      norm_pending <= 1'b0;
      run_min      <= '0;
      run_idx      <= '0;
      surv_valid   <= 1'b0;
      surv_segment <= '0;
      survivors    <= '0;
      symbol_done  <= 1'b0;
      best_state   <= '0;
      best_metric  <= '0;
      norm_event   <= 1'b0;
    end else begin
      surv_valid  <= accept;
      symbol_done <= wrap;
      norm_event  <= wrap && (sym_min >= HALF);
      if (accept) begin
        surv_segment <= seg;
        survivors    <= dec;
        for (int k = 0; k < 2 * P; k++)
          bank[~sel][ST_W'(int'(seg) * 2 * P + k)] <= new_m[k];
        run_min <= sym_min;
        run_idx <= sym_idx;
        if (last) begin
          seg          <= '0;
          sel          <= ~sel;
          norm_pending <= (sym_min >= HALF);
          best_state   <= sym_idx;
          best_metric  <= sym_min;
        end else begin
          seg <= seg + 1'b1;
        end
      end
    end
  end
endmodule
